// File: rtl/mem_xfer_ctrl_pkg.sv
// Shared constants, state encoding and strobe bundle for the load-then-copy controller.
package mem_xfer_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_RWND = 3'd3,
        ST_XFER = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Memory-side control strobes for both address counters and write ports
    typedef struct packed {
        logic wea;
        logic inca;
        logic clra;
        logic web;
        logic incb;
        logic clrb;
    } strobe_t;

endpackage

// File: rtl/mem_xfer_ctrl_counter.sv
// Phase word counter: synchronous clear, enable-increment, terminal-count flag.
module xfer_counter
    import mem_xfer_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] len_latched,
    output logic [ADDR_W-1:0] count,
    output logic              tc_c
);

    logic [ADDR_W-1:0] count_d;
    logic [ADDR_W-1:0] count_q;

    // Clear wins over increment so a phase exit always restarts at zero
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + ADDR_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // Last word of the phase; only consulted when len_latched is non-zero
    assign tc_c  = (count_q == (len_latched - ADDR_W'(1)));

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Load-then-copy controller: fills memory A from a source stream, then copies A into B.
module mem_xfer_ctrl
    import mem_xfer_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              in_valid,
    output logic              WEA,
    output logic              IncA,
    output logic              ClrA,
    output logic              WEB,
    output logic              IncB,
    output logic              ClrB,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] len_d;
    logic              cnt_clr_c;
    logic              cnt_inc_c;
    logic              tc_c;
    strobe_t           stb_c;

    // State and latched job length
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // Next-state and counter control
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_clr_c = 1'b0;
        cnt_inc_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d   = len;
                        state_d = ST_CLR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CLR: begin
                cnt_clr_c = 1'b1;
                state_d   = ST_LOAD;
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (tc_c) begin
                        cnt_clr_c = 1'b1;
                        state_d   = ST_RWND;
                    end else begin
                        cnt_inc_c = 1'b1;
                    end
                end
            end
            ST_RWND: begin
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (tc_c) begin
                    cnt_clr_c = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory strobe decode; only the LOAD write/increment follows in_valid
    always_comb begin
        stb_c = '0;
        unique case (state_q)
            ST_CLR: begin
                stb_c.clra = 1'b1;
                stb_c.clrb = 1'b1;
            end
            ST_LOAD: begin
                stb_c.wea  = in_valid;
                stb_c.inca = in_valid;
            end
            ST_RWND: begin
                stb_c.clra = 1'b1;
            end
            ST_XFER: begin
                stb_c.inca = 1'b1;
                stb_c.web  = 1'b1;
                stb_c.incb = 1'b1;
            end
            default: begin
                stb_c = '0;
            end
        endcase
    end

    assign WEA  = stb_c.wea;
    assign IncA = stb_c.inca;
    assign ClrA = stb_c.clra;
    assign WEB  = stb_c.web;
    assign IncB = stb_c.incb;
    assign ClrB = stb_c.clrb;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    xfer_counter #(
        .ADDR_W(ADDR_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr_c),
        .inc        (cnt_inc_c),
        .len_latched(len_q),
        .count      (count),
        .tc_c       (tc_c)
    );

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Self-checking bench for mem_xfer_ctrl: job-level reference model plus directed pins.
module tb_mem_xfer_ctrl;

    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [AW-1:0] len;
    logic          wea, inca, clra, web, incb, clrb, busy, done;
    logic [AW-1:0] count;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    bit check_en    = 1'b0;

    // Reference model: a running job is described by its length, words loaded so far,
    // and a post-load step index p (1 = rewind, 2..len+1 = copy, len+2 = done).
    bit m_active = 1'b0;
    bit m_empty  = 1'b0;
    bit m_clr    = 1'b0;
    int m_len    = 0;
    int m_loaded = 0;
    int m_p      = 0;

    logic [7:0] exp_s;
    logic [7:0] got_s;
    int         exp_cnt;

    always #5 clk = ~clk;

    mem_xfer_ctrl #(.ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .in_valid(in_valid),
        .WEA     (wea),
        .IncA    (inca),
        .ClrA    (clra),
        .WEB     (web),
        .IncB    (incb),
        .ClrB    (clrb),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    // Advance the job model on the same edge the DUT samples its inputs
    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            m_active = 1'b0; m_empty = 1'b0; m_clr = 1'b0;
            m_len = 0; m_loaded = 0; m_p = 0;
        end else if (m_empty) begin
            m_empty = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                if (len == '0) begin
                    m_empty = 1'b1;
                end else begin
                    m_active = 1'b1; m_clr = 1'b1;
                    m_len = int'(len); m_loaded = 0; m_p = 0;
                end
            end
        end else if (m_clr) begin
            m_clr = 1'b0;
        end else if (m_p == 0) begin
            if (in_valid) begin
                m_loaded++;
                if (m_loaded == m_len) m_p = 1;
            end
        end else if (m_p == m_len + 2) begin
            m_active = 1'b0;
        end else begin
            m_p++;
        end
    end

    // Compare every cycle; bit order wea inca clra web incb clrb busy done
    always @(negedge clk) begin
        if (check_en) begin
            exp_s   = 8'b0000_0000;
            exp_cnt = 0;
            if (m_empty) begin
                exp_s = 8'b0000_0011;
            end else if (m_active) begin
                if (m_clr) begin
                    exp_s = 8'b0010_0110;
                end else if (m_p == 0) begin
                    exp_s   = {in_valid, in_valid, 6'b000010};
                    exp_cnt = m_loaded;
                end else if (m_p == 1) begin
                    exp_s = 8'b0010_0010;
                end else if (m_p <= m_len + 1) begin
                    exp_s   = 8'b0101_1010;
                    exp_cnt = m_p - 2;
                end else begin
                    exp_s = 8'b0000_0011;
                end
            end
            got_s = {wea, inca, clra, web, incb, clrb, busy, done};
            vectors++;
            if (got_s !== exp_s || count !== AW'(exp_cnt)) begin
                miscompares++;
                $display("FAIL cycle_outputs @%0d: got strobes=%b count=%0d, expected strobes=%b count=%0d",
                         cycle, got_s, count, exp_s, exp_cnt);
            end
        end
    end

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One job: start in cycle 0, in_valid low for cycles s_lo..s_hi, optional start/len churn
    task automatic run_job(input int l, input int s_lo, input int s_hi, input bit churn,
                           output int dc, output int nwea, output int nweb,
                           output int nany, output int maxc, output int first_web);
        @(posedge clk); #1;
        start = 1'b1; len = AW'(l); in_valid = 1'b1;
        dc = -1; nwea = 0; nweb = 0; nany = 0; maxc = 0; first_web = -1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            start    = churn ? 1'($urandom_range(0, 1)) : 1'b0;
            if (churn) len = AW'($urandom);
            in_valid = !(c >= s_lo && c <= s_hi);
            @(negedge clk);
            if (wea) nwea++;
            if (web) begin
                nweb++;
                if (first_web < 0) first_web = c;
            end
            if (wea | inca | clra | web | incb | clrb) nany++;
            if (int'(count) > maxc) maxc = int'(count);
            if (done) begin
                dc = c;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
    endtask

    int dc, nwea, nweb, nany, maxc, fweb, ndone;

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_en = 1'b1;
        @(negedge clk);
        check_int("reset_outputs", int'({wea, inca, clra, web, incb, clrb, busy, done, count}), 0);
        @(posedge clk); #1 rst = 1'b0;

        // len=4, no stalls
        run_job(4, -1, -1, 1'b0, dc, nwea, nweb, nany, maxc, fweb);
        check_int("len4_done_cycle", dc, 11);
        check_int("len4_wea_pulses", nwea, 4);
        check_int("len4_web_pulses", nweb, 4);
        check_int("len4_first_web_cycle", fweb, 7);

        // len=3 with a two-cycle source stall inside LOAD
        run_job(3, 4, 5, 1'b0, dc, nwea, nweb, nany, maxc, fweb);
        check_int("len3_stall_done_cycle", dc, 11);
        check_int("len3_stall_wea_pulses", nwea, 3);

        // empty job
        run_job(0, -1, -1, 1'b0, dc, nwea, nweb, nany, maxc, fweb);
        check_int("len0_done_cycle", dc, 1);
        check_int("len0_strobe_cycles", nany, 0);

        // maximum length
        run_job(31, -1, -1, 1'b0, dc, nwea, nweb, nany, maxc, fweb);
        check_int("len31_done_cycle", dc, 65);
        check_int("len31_wea_pulses", nwea, 31);
        check_int("len31_web_pulses", nweb, 31);
        check_int("len31_max_count", maxc, 30);

        // start and len churn while busy
        run_job(5, -1, -1, 1'b1, dc, nwea, nweb, nany, maxc, fweb);
        check_int("churn_done_cycle", dc, 13);
        check_int("churn_wea_pulses", nwea, 5);
        check_int("churn_web_pulses", nweb, 5);

        // reset in the middle of an len=8 copy phase
        @(posedge clk); #1;
        start = 1'b1; len = AW'(8); in_valid = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        check_int("abort_in_xfer", int'({web, busy}), 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_int("abort_outputs_zero", int'({wea, inca, clra, web, incb, clrb, busy, done, count}), 0);
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_int("abort_no_done", ndone, 0);
        run_job(2, -1, -1, 1'b0, dc, nwea, nweb, nany, maxc, fweb);
        check_int("after_abort_len2_done_cycle", dc, 7);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst      = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 3) == 0);
            len      = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
